alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencing controller that shares one 32-bit `ALU` instance between two requesters. Each requester issues a valid/ready operation request carrying an opcode and two operands. The block arbitrates round-robin, registers the winner's operands, and decodes the opcode into the ALU's `Binvert`/`Carryin`/`Operation` controls. It captures `Result`/`CarryOut` and returns them on a single tagged response channel. It sits between the instruction-issue logic and the shared ALU datapath.

## Interface
- `WIDTH`, 32, operand/result width; must match the ALU instance.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset; one clock, asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  request present on port 0 / 1.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_op`, `req1_op`  in  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB; all others illegal.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `alu_in1`, `alu_in2`  out  WIDTH  to ALU `in1`/`in2`.
- `alu_binvert`, `alu_carryin`  out  1  to ALU `Binvert`/`Carryin`.
- `alu_operation`  out  2  to ALU `Operation`.
- `alu_result`  in  WIDTH  from ALU `Result`.
- `alu_carryout`  in  1  from ALU `CarryOut`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_carry`  out  1  captured CarryOut.
- `rsp_zero`  out  1  `rsp_result == 0`.
- `rsp_err`  out  1  illegal opcode; result forced to 0.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- **IDLE**
  - `reqN_ready` is 1 only for the granted port, and only when that port's valid is high.
  - Arbitration:
    - Only one port valid: that port wins.
    - Both ports valid: the port not granted last time wins.
    - The `last_grant` register resets to 1, so port 0 wins the first contention.
  - On acceptance, register op, a, b and id, update `last_grant`, and go to ISSUE.
- **ISSUE** (exactly one cycle)
  - Drive the registered operands and decoded controls to the ALU:
    - AND: `Operation`=00, `Binvert`=0, `Carryin`=0.
    - OR: `Operation`=01, `Binvert`=0, `Carryin`=0.
    - ADD: `Operation`=10, `Binvert`=0, `Carryin`=0.
    - SUB: `Operation`=10, `Binvert`=1, `Carryin`=1 (two's complement).
  - Illegal opcode: controls are the AND encoding. Capture `rsp_result`=0, `rsp_carry`=0, `rsp_err`=1.
  - At the end of the cycle, capture `alu_result`/`alu_carryout` into the response registers and go to RESP.
- **RESP**
  - `rsp_valid`=1; all `rsp_*` outputs are held stable.
  - `rsp_valid && rsp_ready` sends the FSM to IDLE next cycle.
  - Without `rsp_ready`, the FSM stays in RESP indefinitely.
  - Both `reqN_ready` are 0 in ISSUE and RESP.
- **ALU outputs outside ISSUE:** `alu_in1`/`alu_in2` show the operand registers; controls show the last decoded values. Downstream logic must not sample them.
- **Zero flag:** `rsp_zero` is registered alongside the result; it is 1 for an illegal op.
- **Width:** CarryOut is the carry out of bit WIDTH-1, taken directly from the ALU. For SUB, carry=1 means no borrow (a >= b unsigned).

## Timing
- **Reset values:** `req0_ready`=`req1_ready`=0 (FSM in IDLE with no valid inputs), `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_carry`=0, `rsp_zero`=0, `rsp_err`=0, `alu_in1`=`alu_in2`=0, `alu_binvert`=`alu_carryin`=0, `alu_operation`=00, `last_grant`=1.
- **Latency:** accept at edge N; ISSUE during cycle N+1; `rsp_valid` high from cycle N+2.
- **Throughput:** best case one operation per 3 cycles, with `rsp_ready` tied high.
- **Ready dependence:** `reqN_ready` is combinational from state, `last_grant` and the valids. It never depends on `rsp_ready`.
- **Handshake in RESP:** a `rsp_ready` pulse completes the response in that same cycle. New requests are accepted no earlier than the following (IDLE) cycle.
- **Reset mid-operation:** asynchronous return to IDLE; all outputs take reset values immediately and the in-flight operation is dropped.
- **Requester rules:**
  - A requester holds `valid` and its payload until it sees `ready`.
  - A requester dropping `valid` before `ready` is legal; its request is simply not taken.

## Test plan
- **Port 0, op sequence:** a=0xA5A5A5A5, b=0x5A5A5A5A.
  - AND → result 0x00000000, zero=1, carry=0, id=0.
  - OR → 0xFFFFFFFF.
  - ADD → 0xFFFFFFFF, carry=0.
  - Check response 2 cycles after each accept.
- **SUB, same operands:** expect `alu_binvert`=1 and `alu_carryin`=1 in ISSUE; result 0x4B4B4B4B, carry=1.
- **SUB, borrow and zero:**
  - 5-5 → 0, zero=1, carry=1.
  - 0-1 → 0xFFFFFFFF, carry=0.
- **Contention:** both ports valid continuously with `rsp_ready`=1.
  - Grants alternate 0,1,0,1.
  - `rsp_id` sequence matches the grants.
  - One accept every 3 cycles.
- **Back-pressure and illegal op:**
  - Hold `rsp_ready`=0 for 10 cycles: `rsp_*` stays stable and both `reqN_ready` stay 0.
  - Opcode 011 → `rsp_err`=1, result=0.
- **Async reset:** assert `reset_n` low in ISSUE and again in RESP. Outputs immediately take reset values, and the next contention grants port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational 32-bit ALU between two requesters. Each requester
// presents an opcode and two operands on a valid/ready channel. The block
// picks a winner round-robin, registers its operands, drives the ALU for one
// cycle with the decoded controls, captures the ALU outputs, and returns them
// on a single tagged response channel.
//
// Ports
//   clk                     rising-edge clock
//   reset_n                 asynchronous active-low reset
//   req0_valid/req1_valid   request present on port 0 / 1
//   req0_ready/req1_ready   request accepted this cycle
//   req0_op/req1_op         opcode: 000 AND, 001 OR, 010 ADD, 110 SUB
//   req0_a/b, req1_a/b      operands
//   alu_in1/alu_in2         operands to the shared ALU
//   alu_binvert             ALU Binvert control
//   alu_carryin             ALU Carryin control
//   alu_operation           ALU Operation select
//   alu_result              ALU Result
//   alu_carryout            ALU CarryOut (carry out of bit WIDTH-1)
//   rsp_valid/rsp_ready     response handshake
//   rsp_id                  requester that owns the response
//   rsp_result/rsp_carry    captured ALU result / carry
//   rsp_zero                captured result is zero
//   rsp_err                 illegal opcode; result forced to 0
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_binvert,
  output logic             alu_carryin,
  output logic [1:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  state_t           state;
  state_t           state_next;

  logic             last_grant;
  logic             grant;
  logic             accept;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;

  logic             illegal_op;

  // Round-robin choice. With both ports valid the port that did not win
  // last time gets the grant; last_grant resets to 1 so port 0 wins the
  // first contention. grant is only meaningful when some port is valid.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready depends only on state, last_grant and the valids, never on
  // rsp_ready, so requesters cannot form a loop through the response side.
  always_comb begin
    accept     = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: ISSUE always lasts exactly one cycle, RESP waits for
  // the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the winning request and remember who won for the next
  // contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_q       <= grant ? req1_op : req0_op;
      a_q        <= grant ? req1_a  : req0_a;
      b_q        <= grant ? req1_b  : req0_b;
      id_q       <= grant;
      last_grant <= grant;
    end
  end

  // Opcode decode. The controls follow the held opcode register, so outside
  // ISSUE they simply keep showing the last decoded values. Illegal opcodes
  // drive the harmless AND encoding.
  always_comb begin
    alu_operation = 2'b00;
    alu_binvert   = 1'b0;
    alu_carryin   = 1'b0;
    illegal_op    = 1'b0;
    case (op_q)
      OP_AND: begin
        alu_operation = 2'b00;
      end
      OP_OR: begin
        alu_operation = 2'b01;
      end
      OP_ADD: begin
        alu_operation = 2'b10;
      end
      OP_SUB: begin
        // a - b computed as a + ~b + 1
        alu_operation = 2'b10;
        alu_binvert   = 1'b1;
        alu_carryin   = 1'b1;
      end
      default: begin
        illegal_op = 1'b1;
      end
    endcase
  end

  always_comb begin
    alu_in1 = a_q;
    alu_in2 = b_q;
  end

  // Response capture at the end of ISSUE. The registers then hold still
  // through RESP regardless of back-pressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state == ISSUE) begin
      rsp_id     <= id_q;
      rsp_result <= illegal_op ? '0   : alu_result;
      rsp_carry  <= illegal_op ? 1'b0 : alu_carryout;
      rsp_zero   <= illegal_op || (alu_result == '0);
      rsp_err    <= illegal_op;
    end
  end

  always_comb begin
    rsp_valid = (state == RESP);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A behavioural ALU closes the loop on
// the alu_* ports. Expected responses are computed from the requested
// opcode/operands and queued at acceptance, then popped and compared when
// the response appears.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic [31:0] alu_in1, alu_in2;
  logic        alu_binvert, alu_carryin;
  logic [1:0]  alu_operation;
  logic [31:0] alu_result;
  logic        alu_carryout;

  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_zero, rsp_err;

  rsp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic        model_last;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_op       (req0_op),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_op       (req1_op),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_binvert   (alu_binvert),
    .alu_carryin   (alu_carryin),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_carryout  (alu_carryout),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_carry     (rsp_carry),
    .rsp_zero      (rsp_zero),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ripple ALU: the adder always runs, so CarryOut reflects
  // in1 + (possibly inverted) in2 + Carryin for every operation.
  logic [31:0] b_eff;
  logic [32:0] alu_sum;
  always_comb begin
    b_eff        = alu_binvert ? ~alu_in2 : alu_in2;
    alu_sum      = {1'b0, alu_in1} + {1'b0, b_eff} + {32'b0, alu_carryin};
    alu_carryout = alu_sum[32];
    case (alu_operation)
      2'b00:   alu_result = alu_in1 & b_eff;
      2'b01:   alu_result = alu_in1 | b_eff;
      2'b10:   alu_result = alu_sum[31:0];
      default: alu_result = '0;
    endcase
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic rsp_t expectResult(input logic id, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    rsp_t        r;
    logic [32:0] s;
    r.id  = id;
    r.err = 1'b0;
    s     = {1'b0, a} + {1'b0, b};
    case (op)
      3'b000: begin r.result = a & b;    r.carry = s[32]; end
      3'b001: begin r.result = a | b;    r.carry = s[32]; end
      3'b010: begin r.result = s[31:0];  r.carry = s[32]; end
      3'b110: begin r.result = a - b;    r.carry = (a >= b); end
      default: begin r.result = '0; r.carry = 1'b0; r.err = 1'b1; end
    endcase
    r.zero = (r.result == 32'd0);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h, expected %0h at cycle %0d",
               tag, actual, expected, cyc);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req0_ready"}, req0_ready, 0);
    checkOutput({tag, "_req1_ready"}, req1_ready, 0);
    checkOutput({tag, "_rsp_valid"},  rsp_valid, 0);
    checkOutput({tag, "_rsp_id"},     rsp_id, 0);
    checkOutput({tag, "_rsp_result"}, rsp_result, 0);
    checkOutput({tag, "_rsp_carry"},  rsp_carry, 0);
    checkOutput({tag, "_rsp_zero"},   rsp_zero, 0);
    checkOutput({tag, "_rsp_err"},    rsp_err, 0);
    checkOutput({tag, "_alu_in1"},    alu_in1, 0);
    checkOutput({tag, "_alu_in2"},    alu_in2, 0);
    checkOutput({tag, "_binvert"},    alu_binvert, 0);
    checkOutput({tag, "_carryin"},    alu_carryin, 0);
    checkOutput({tag, "_operation"},  alu_operation, 0);
  endtask

  // Pops the oldest expected response and compares it with the DUT outputs.
  task automatic compareResponse(output rsp_t held);
    rsp_t e;
    e = '0;
    checkOutput("sb_has_entry", 64'(sb.size() != 0), 1);
    if (sb.size() != 0) e = sb.pop_front();
    checkOutput("rsp_valid",  rsp_valid, 1);
    checkOutput("rsp_id",     rsp_id, e.id);
    checkOutput("rsp_result", rsp_result, e.result);
    checkOutput("rsp_carry",  rsp_carry, e.carry);
    checkOutput("rsp_zero",   rsp_zero, e.zero);
    checkOutput("rsp_err",    rsp_err, e.err);
    held = e;
  endtask

  // Presents one request on a single port, waits (bounded) for acceptance,
  // queues the expected response and drops valid. Returns in ISSUE.
  task automatic applyStimulus(input logic port, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    int n;
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      @(posedge clk); #3;
      n++;
    end
    checkOutput("accept_ready", port ? req1_ready : req0_ready, 1);
    checkOutput("accept_other", port ? req0_ready : req1_ready, 0);
    sb.push_back(expectResult(port, op, a, b));
    model_last = port;
    @(posedge clk); #2;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
  endtask

  // One complete operation with rsp_ready high: checks the ISSUE-cycle ALU
  // drive, a response exactly two cycles after acceptance, and the return
  // to IDLE.
  task automatic runOp(input logic port, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    rsp_t        held;
    logic [1:0]  exp_oper;
    exp_oper = (op == 3'b001) ? 2'b01 :
               ((op == 3'b010) || (op == 3'b110)) ? 2'b10 : 2'b00;
    applyStimulus(port, op, a, b);
    checkOutput("issue_req0_ready", req0_ready, 0);
    checkOutput("issue_req1_ready", req1_ready, 0);
    checkOutput("issue_rsp_valid",  rsp_valid, 0);
    checkOutput("issue_alu_in1",    alu_in1, a);
    checkOutput("issue_alu_in2",    alu_in2, b);
    checkOutput("issue_operation",  alu_operation, exp_oper);
    checkOutput("issue_binvert",    alu_binvert, (op == 3'b110));
    checkOutput("issue_carryin",    alu_carryin, (op == 3'b110));
    @(posedge clk); #2;
    compareResponse(held);
    @(posedge clk); #2;
    checkOutput("idle_rsp_valid", rsp_valid, 0);
  endtask

  // One arbitration round with both ports valid; the winner comes from the
  // bench's own round-robin model.
  task automatic contendOnce(output int accept_cyc);
    logic w;
    rsp_t held;
    int   n;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    w = ~model_last;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(posedge clk); #3;
      n++;
    end
    checkOutput("grant_port0", req0_ready, !w);
    checkOutput("grant_port1", req1_ready, w);
    sb.push_back(expectResult(w, w ? req1_op : req0_op,
                              w ? req1_a : req0_a, w ? req1_b : req0_b));
    model_last = w;
    accept_cyc = cyc;
    @(posedge clk); #2;
    checkOutput("cont_issue_ready0", req0_ready, 0);
    checkOutput("cont_issue_ready1", req1_ready, 0);
    @(posedge clk); #2;
    compareResponse(held);
    @(posedge clk); #2;
  endtask

  initial begin
    rsp_t held;
    int   acc_now;
    int   acc_prev;

    reset_n    = 1'b0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
    model_last = 1'b1;
    #2;
    checkResetValues("rst");
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #2;

    $display("[TB] port 0 op sequence");
    runOp(1'b0, 3'b000, 32'hA5A5A5A5, 32'h5A5A5A5A);
    runOp(1'b0, 3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A);
    runOp(1'b0, 3'b010, 32'hA5A5A5A5, 32'h5A5A5A5A);
    runOp(1'b0, 3'b110, 32'hA5A5A5A5, 32'h5A5A5A5A);

    $display("[TB] SUB borrow and zero");
    runOp(1'b0, 3'b110, 32'd5, 32'd5);
    runOp(1'b1, 3'b110, 32'd0, 32'd1);

    $display("[TB] contention");
    req0_op = 3'b010; req0_a = 32'h00000010; req0_b = 32'h00000020;
    req1_op = 3'b110; req1_a = 32'h00000030; req1_b = 32'h00000031;
    acc_prev = 0;
    for (int k = 0; k < 4; k++) begin
      contendOnce(acc_now);
      if (k > 0) checkOutput("accept_interval", acc_now - acc_prev, 3);
      acc_prev = acc_now;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #2;

    $display("[TB] back-pressure with illegal opcode");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 3'b011, 32'hDEADBEEF, 32'h12345678);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checkOutput("bp_issue_ready0", req0_ready, 0);
    checkOutput("bp_issue_ready1", req1_ready, 0);
    @(posedge clk); #2;
    compareResponse(held);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      checkOutput("bp_rsp_valid",  rsp_valid, 1);
      checkOutput("bp_rsp_result", rsp_result, held.result);
      checkOutput("bp_rsp_err",    rsp_err, held.err);
      checkOutput("bp_rsp_zero",   rsp_zero, held.zero);
      checkOutput("bp_rsp_id",     rsp_id, held.id);
      checkOutput("bp_req0_ready", req0_ready, 0);
      checkOutput("bp_req1_ready", req1_ready, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge clk); #2;
    checkOutput("bp_release", rsp_valid, 0);

    $display("[TB] async reset during ISSUE");
    applyStimulus(1'b0, 3'b010, 32'd7, 32'd9);
    reset_n = 1'b0;
    #1;
    checkResetValues("rstIssue");
    sb.delete();
    model_last = 1'b1;
    #1;
    reset_n = 1'b1;
    @(posedge clk); #2;
    req0_op = 3'b001; req0_a = 32'h0000F000; req0_b = 32'h0000000F;
    req1_op = 3'b000; req1_a = 32'hFFFFFFFF; req1_b = 32'h00FF00FF;
    contendOnce(acc_now);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #2;

    $display("[TB] async reset during RESP");
    applyStimulus(1'b0, 3'b001, 32'd1, 32'd2);
    @(posedge clk); #2;
    checkOutput("rstResp_in_resp", rsp_valid, 1);
    reset_n = 1'b0;
    #1;
    checkResetValues("rstResp");
    sb.delete();
    model_last = 1'b1;
    #1;
    reset_n = 1'b1;
    @(posedge clk); #2;
    contendOnce(acc_now);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #2;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
